// File: rtl/case_1_prod_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : case_1_accum_pkg
// Purpose  : Shared types, defaults and the saturating-add helper for the
//            case_1 product accumulator.
// Contents : state_e        - accumulator FSM state encoding
//            ACC_W_DEFAULT  - default accumulator width
//            sat_res_t      - {ovf, sum} result of sat_add
//            sat_add()      - width-aware saturating add; only referenced
//                             when CASE_1_ACC_SAT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
package case_1_accum_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_e;

  localparam int ACC_W_DEFAULT = 16;

  typedef struct packed {
    logic        ovf;
    logic [63:0] sum;
  } sat_res_t;

  // a and b carry w-bit two's complement values (sign-extended to 64 bits).
  // The low w bits of the returned sum hold the saturated w-bit result.
  // Overflow is the classic rule: operands agree in sign, result does not.
  function automatic sat_res_t sat_add(input logic [63:0] a,
                                       input logic [63:0] b,
                                       input int unsigned w);
    sat_res_t   r;
    logic [63:0] raw;
    logic [63:0] max_pos;
    logic [5:0]  msb;
    msb     = 6'(w - 1);
    raw     = a + b;
    max_pos = (64'd1 << msb) - 64'd1;
    r.ovf   = (a[msb] == b[msb]) && (raw[msb] != a[msb]);
    // ~max_pos is -2^(w-1) in its low w bits
    if (r.ovf) r.sum = a[msb] ? ~max_pos : max_pos;
    else       r.sum = raw;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/case_1_prod_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : case_1_prod_accum_if
// Purpose  : Stream bus between the case_1 multiplier, the product
//            accumulator and the result writeback.
// Signals  : in_data/in_valid/in_ready   product stream (upstream side)
//            acc_clr                     abort of the partial group
//            out_data/out_valid/out_ready group sum stream (downstream side)
//            sat_flag                    only with CASE_1_ACC_SAT_EN
// Modports : master - environment driving products and consuming sums
//            slave  - the accumulator
// Revision : 1.0 - initial release
// ============================================================================
interface case_1_prod_accum_if #(
  parameter int PROD_WIDTH = 7,
  parameter int ACC_WIDTH  = 16
);

  logic                         acc_clr;
  logic signed [PROD_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [ACC_WIDTH-1:0]  out_data;
  logic                         out_valid;
  logic                         out_ready;
`ifdef CASE_1_ACC_SAT_EN
  logic                         sat_flag;
`endif

  modport master (
    output acc_clr, in_data, in_valid, out_ready,
`ifdef CASE_1_ACC_SAT_EN
    input  sat_flag,
`endif
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  acc_clr, in_data, in_valid, out_ready,
`ifdef CASE_1_ACC_SAT_EN
    output sat_flag,
`endif
    output in_ready, out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/case_1_prod_accum_adder.sv
`default_nettype none
// ============================================================================
// Module   : case_1_acc_adder
// Purpose  : Combinational datapath of the product accumulator: sign-extends
//            the product, then either loads it (first beat of a group) or
//            adds it to the running sum. Wraps by default; saturates when
//            CASE_1_ACC_SAT_EN is defined.
// Ports    : acc    in  ACC_WIDTH   running sum
//            prod   in  PROD_WIDTH  signed product
//            first  in  1           first beat: result = ext(prod)
//            result out ACC_WIDTH   new sum
//            ovf    out 1           this add overflowed (never on a load)
// Macro    : CASE_1_ACC_SAT_EN
// Revision : 1.0 - initial release
// ============================================================================
module case_1_acc_adder
  import case_1_accum_pkg::*;
#(
  parameter int PROD_WIDTH = 7,
  parameter int ACC_WIDTH  = ACC_W_DEFAULT
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [PROD_WIDTH-1:0] prod,
  input  logic                         first,
  output logic signed [ACC_WIDTH-1:0]  result,
  output logic                         ovf
);

  logic signed [ACC_WIDTH-1:0] w_ext;

  // Size cast of a signed operand sign-extends.
  assign w_ext = ACC_WIDTH'(prod);

`ifdef CASE_1_ACC_SAT_EN
  sat_res_t w_sat;
  logic     w_unused_sat_hi;

  assign w_sat           = sat_add(64'(acc), 64'(w_ext), ACC_WIDTH);
  assign w_unused_sat_hi = ^w_sat.sum[63:ACC_WIDTH];

  always_comb begin
    result = w_ext;
    ovf    = 1'b0;
    if (!first) begin
      result = w_sat.sum[ACC_WIDTH-1:0];
      ovf    = w_sat.ovf;
    end
  end
`else
  logic signed [ACC_WIDTH-1:0] w_wrap;
  logic                        w_wrap_ovf;

  assign w_wrap     = acc + w_ext;
  assign w_wrap_ovf = (acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                      (w_wrap[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  always_comb begin
    result = w_ext;
    ovf    = 1'b0;
    if (!first) begin
      result = w_wrap;
      ovf    = w_wrap_ovf;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/case_1_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : case_1_prod_accum
// Purpose  : Streaming signed accumulator behind the case_1 multiplier. Sums
//            LEN consecutive accepted products and presents each group sum
//            on a registered valid/ready output. Overflow wraps, or
//            saturates when CASE_1_ACC_SAT_EN is defined (adds sat_flag).
// Ports    : ap_clk    in  clock, rising edge
//            ap_rst_n  in  asynchronous active-low reset
//            bus       case_1_prod_accum_if.slave (acc_clr, in_*, out_*)
//            The interface PROD_WIDTH/ACC_WIDTH must match this module's.
// Macro    : CASE_1_ACC_SAT_EN
// Revision : 1.0 - initial release
// ============================================================================
module case_1_prod_accum
  import case_1_accum_pkg::*;
#(
  parameter  int PROD_WIDTH = 7,
  parameter  int ACC_WIDTH  = ACC_W_DEFAULT,  // >= PROD_WIDTH
  parameter  int LEN        = 8,              // >= 1
  localparam int CNT_WIDTH  = $clog2(LEN + 1)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  case_1_prod_accum_if.slave       bus
);

  state_e                      r_state;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_out_data;
  logic                        r_out_valid;

  logic                        w_in_ready;
  logic                        w_accept;
  logic                        w_first;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_ovf;

  // in_ready must not depend on in_valid or the output side.
  assign w_in_ready = (r_state == ST_ACCUM) && !bus.acc_clr;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == CNT_WIDTH'(LEN - 1));

  case_1_acc_adder #(
    .PROD_WIDTH (PROD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_adder (
    .acc    (r_acc),
    .prod   (bus.in_data),
    .first  (w_first),
    .result (w_sum),
    .ovf    (w_ovf)
  );

`ifdef CASE_1_ACC_SAT_EN
  logic r_sat_sticky;  // any saturation so far in the open group
  logic r_sat_flag;    // presented alongside out_data
  assign bus.sat_flag = r_sat_flag;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifdef CASE_1_ACC_SAT_EN
      r_sat_sticky <= 1'b0;
      r_sat_flag   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (bus.acc_clr) begin
            // Abort wins over a valid beat in the same cycle.
            r_cnt <= '0;
            r_acc <= '0;
`ifdef CASE_1_ACC_SAT_EN
            r_sat_sticky <= 1'b0;
            r_sat_flag   <= 1'b0;
`endif
          end else if (w_accept) begin
            r_acc <= w_sum;
            if (w_last) begin
              r_out_data  <= w_sum;
              r_out_valid <= 1'b1;
              r_cnt       <= '0;
              r_state     <= ST_OUT;
`ifdef CASE_1_ACC_SAT_EN
              r_sat_flag   <= r_sat_sticky | w_ovf;
              r_sat_sticky <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
`ifdef CASE_1_ACC_SAT_EN
              r_sat_sticky <= r_sat_sticky | w_ovf;
`endif
            end
          end
        end
        ST_OUT: begin
          // acc_clr is ignored here: the finished sum is always delivered.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACCUM;
`ifdef CASE_1_ACC_SAT_EN
            r_sat_flag  <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_case_1_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_1_prod_accum
// Purpose  : Self-checking bench for case_1_prod_accum. Three instances:
//            A (LEN=4, ACC=16), B (LEN=4, ACC=8), C (LEN=1, ACC=16).
//            Expected sums are queued when stimulus is issued; per-instance
//            monitors pop and compare on each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_case_1_prod_accum;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk = ~clk;

  case_1_prod_accum_if #(.PROD_WIDTH(7), .ACC_WIDTH(16)) bus_a ();
  case_1_prod_accum_if #(.PROD_WIDTH(7), .ACC_WIDTH(8))  bus_b ();
  case_1_prod_accum_if #(.PROD_WIDTH(7), .ACC_WIDTH(16)) bus_c ();

  case_1_prod_accum #(.PROD_WIDTH(7), .ACC_WIDTH(16), .LEN(4)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n_a), .bus(bus_a));
  case_1_prod_accum #(.PROD_WIDTH(7), .ACC_WIDTH(8), .LEN(4)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_b));
  case_1_prod_accum #(.PROD_WIDTH(7), .ACC_WIDTH(16), .LEN(1)) u_c (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_c));

  int n_vec = 0;
  int n_err = 0;

  longint q_a[$];
  longint q_b[$];
  longint q_c[$];
`ifdef CASE_1_ACC_SAT_EN
  longint qs_b[$];
`endif

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (bus_a.out_valid && bus_a.out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_output", 1, 0);
      else chk("a_sum", longint'(bus_a.out_data), q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus_b.out_valid && bus_b.out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_output", 1, 0);
      else begin
        chk("b_sum", longint'(bus_b.out_data), q_b.pop_front());
`ifdef CASE_1_ACC_SAT_EN
        if (qs_b.size() != 0) chk("b_sat_flag", longint'(bus_b.sat_flag), qs_b.pop_front());
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (bus_c.out_valid && bus_c.out_ready) begin
      if (q_c.size() == 0) chk("c_unexpected_output", 1, 0);
      else chk("c_sum", longint'(bus_c.out_data), q_c.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // Each send returns #1 after the edge on which the beat was accepted.
  task automatic send_a(input logic signed [6:0] v);
    int n = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = v;
    @(negedge clk);
    while (!bus_a.in_ready && n < 50) begin n++; @(negedge clk); end
    if (!bus_a.in_ready) chk("a_in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic signed [6:0] v);
    int n = 0;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = v;
    @(negedge clk);
    while (!bus_b.in_ready && n < 50) begin n++; @(negedge clk); end
    if (!bus_b.in_ready) chk("b_in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic send_c(input logic signed [6:0] v);
    int n = 0;
    bus_c.in_valid = 1'b1;
    bus_c.in_data  = v;
    @(negedge clk);
    while (!bus_c.in_ready && n < 50) begin n++; @(negedge clk); end
    if (!bus_c.in_ready) chk("c_in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus_c.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_a.acc_clr = 0; bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
    bus_b.acc_clr = 0; bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 1;
    bus_c.acc_clr = 0; bus_c.in_valid = 0; bus_c.in_data = '0; bus_c.out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_out_valid", longint'(bus_a.out_valid), 0);
    chk("a_reset_out_data",  longint'(bus_a.out_data), 0);
    rst_n_a = 1'b1;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("a_reset_in_ready", longint'(bus_a.in_ready), 1);
    @(posedge clk); #1;

    // Group 1: 3 - 2 + 5 + 1 = 7, with backpressure afterwards
    q_a.push_back(7);
    send_a(3); send_a(-2); send_a(5); send_a(1);
    chk("a_latency_out_valid", longint'(bus_a.out_valid), 1);
    chk("a_out_in_ready",      longint'(bus_a.in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("a_bp_out_data", longint'(bus_a.out_data), 7);
      chk("a_bp_in_ready", longint'(bus_a.in_ready), 0);
    end
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("a_release_in_ready",  longint'(bus_a.in_ready), 1);
    chk("a_release_out_valid", longint'(bus_a.out_valid), 0);

    // Group 2: -64 x 4 = -256
    q_a.push_back(-256);
    for (int i = 0; i < 4; i++) send_a(-64);

    // Abort after 10, 20; the beat offered during acc_clr is refused
    q_a.push_back(4);
    send_a(10); send_a(20);
    bus_a.acc_clr  = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 7'sd33;
    @(negedge clk);
    chk("a_clr_in_ready", longint'(bus_a.in_ready), 0);
    @(posedge clk); #1;
    bus_a.acc_clr  = 1'b0;
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_a(1);
    @(posedge clk); #1;

    // Async reset mid-group
    send_a(2); send_a(2);
    #2 rst_n_a = 1'b0;
    #1;
    chk("a_rst_mid_out_valid", longint'(bus_a.out_valid), 0);
    chk("a_rst_mid_out_data",  longint'(bus_a.out_data), 0);
    @(posedge clk); #1 rst_n_a = 1'b1;

    // Async reset while a sum (20) is pending
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(5);
    chk("a_pending_out_valid", longint'(bus_a.out_valid), 1);
    chk("a_pending_out_data",  longint'(bus_a.out_data), 20);
    #2 rst_n_a = 1'b0;
    #1;
    chk("a_rst_out_out_valid", longint'(bus_a.out_valid), 0);
    chk("a_rst_out_out_data",  longint'(bus_a.out_data), 0);
    chk("a_rst_out_in_ready",  longint'(bus_a.in_ready), 1);
    @(posedge clk); #1 rst_n_a = 1'b1;
    bus_a.out_ready = 1'b1;
    q_a.push_back(8);
    for (int i = 0; i < 4; i++) send_a(2);

    // Instance B: 63 x 4 at ACC_WIDTH=8
`ifdef CASE_1_ACC_SAT_EN
    q_b.push_back(127);
    qs_b.push_back(1);
`else
    q_b.push_back(-4);
`endif
    for (int i = 0; i < 4; i++) send_b(63);
    chk("b_latency_out_valid", longint'(bus_b.out_valid), 1);

    // Instance C: LEN=1
    q_c.push_back(-5);
    send_c(-5);
    chk("c1_out_valid", longint'(bus_c.out_valid), 1);
    chk("c1_in_ready",  longint'(bus_c.in_ready), 0);
    @(posedge clk); #1;
    chk("c1_in_ready_after", longint'(bus_c.in_ready), 1);
    q_c.push_back(6);
    send_c(6);
    chk("c2_out_valid", longint'(bus_c.out_valid), 1);
    chk("c2_in_ready",  longint'(bus_c.in_ready), 0);
    @(posedge clk); #1;
    chk("c2_in_ready_after", longint'(bus_c.in_ready), 1);

    // Drain: every queued sum must have been seen
    for (int i = 0; i < 40 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++)
      @(negedge clk);
    chk("scoreboard_leftover", longint'(q_a.size() + q_b.size() + q_c.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
